tx_segment_scheduler: RTL and testbench

//  Sequences the Ethernet TX path: emits (txid, segment_num) tuples plus one pkt_start pulse per packet to
//  the UDP frame generator and the tx memory controller, in order txid 1..R (outer) x segment 0..S-1 (inner).
//  The txid==1 pass fills per-segment replay BRAMs; later passes replay them. Frames end on the memory

---
 rtl/tx_segment_scheduler.sv | 137 +++++++++++++
 tb/tb_tx_segment_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_segment_scheduler.sv
// tx_segment_scheduler: walks (txid 1..R) x (segment 0..S-1) packet tuples until maxdetect ends a frame; TX_SCHED_TIMEOUT_EN adds a pkt_done watchdog.
// pkt_start 1 cycle after enable in IDLE, IFG_CYCLES+1 after pkt_done; stalls in WAIT_DONE until pkt_done (or watchdog expiry).
module tx_segment_scheduler #(
  parameter int IFG_CYCLES = 12,
  parameter int SEG_W      = 16
`ifdef TX_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic             clk125MHz,
  input  logic             rst,
  input  logic             enable,
  input  logic [7:0]       redundancy,
  input  logic [SEG_W-1:0] segment_num_max,
  input  logic             maxdetect,
  input  logic             pkt_done,
  output logic             pkt_start,
  output logic [7:0]       txid,
  output logic [SEG_W-1:0] segment_num,
  output logic             busy,
  output logic             frame_done,
  output logic             timeout_err
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_DONE, GAP, FRAME_END} state_t;

  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES - 1);

  state_t           state;
  logic [7:0]       r_l;
  logic [SEG_W-1:0] s_l;
  logic             ovr;
  logic [GAP_W-1:0] gap_cnt;
  logic             wd_expire;

`ifdef TX_SCHED_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;

  // A missing pkt_done is treated as a completed packet so the frame keeps moving.
  assign wd_expire = (state == WAIT_DONE) && !pkt_done && (wd_cnt == WD_LAST);

  always_ff @(posedge clk125MHz) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != WAIT_DONE) wd_cnt <= '0;
      else                    wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_expire) timeout_err <= 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk125MHz) begin
    if (rst) begin
      state       <= IDLE;
      pkt_start   <= 1'b0;
      txid        <= 8'd1;
      segment_num <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      r_l         <= '0;
      s_l         <= '0;
      ovr         <= 1'b0;
      gap_cnt     <= '0;
    end else begin
      pkt_start  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            r_l         <= (redundancy == 8'd0) ? 8'd1 : redundancy;
            s_l         <= (segment_num_max == '0) ? SEG_W'(1) : segment_num_max;
            ovr         <= 1'b0;
            txid        <= 8'd1;
            segment_num <= '0;
            pkt_start   <= 1'b1;
            busy        <= 1'b1;
            state       <= LAUNCH;
          end
        end
        LAUNCH: state <= WAIT_DONE;
        WAIT_DONE: begin
          // Only the txid==1 pass reads fresh VRAM, so only it can see end of frame.
          if (maxdetect && (txid == 8'd1)) ovr <= 1'b1;
          if (pkt_done || wd_expire) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (segment_num < s_l - SEG_W'(1)) begin
              segment_num <= segment_num + SEG_W'(1);
              pkt_start   <= 1'b1;
              state       <= LAUNCH;
            end else if (txid < r_l) begin
              segment_num <= '0;
              txid        <= txid + 8'd1;
              pkt_start   <= 1'b1;
              state       <= LAUNCH;
            end else begin
              segment_num <= '0;
              txid        <= 8'd1;
              if (ovr) begin
                frame_done <= 1'b1;
                state      <= FRAME_END;
              end else begin
                pkt_start <= 1'b1;
                state     <= LAUNCH;
              end
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        FRAME_END: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_segment_scheduler.sv
// Directed bench for tx_segment_scheduler with IFG_CYCLES=12: packet spacing is pkt_done offset + 13 cycles.
module tb_tx_segment_scheduler;

  logic        clk125MHz = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  redundancy = 8'd0;
  logic [15:0] segment_num_max = 16'd0;
  logic        maxdetect = 1'b0;
  logic        pkt_done = 1'b0;
  logic        pkt_start;
  logic [7:0]  txid;
  logic [15:0] segment_num;
  logic        busy;
  logic        frame_done;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_start = 0;
  int n_fd = 0;

  logic [7:0]  t2_id  [6] = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3};
  logic [15:0] t2_seg [6] = '{16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1};
  logic [7:0]  t4_id  [4] = '{8'd1, 8'd1, 8'd2, 8'd2};
  logic [15:0] t4_seg [4] = '{16'd0, 16'd1, 16'd0, 16'd1};

  tx_segment_scheduler dut (
    .clk125MHz      (clk125MHz),
    .rst            (rst),
    .enable         (enable),
    .redundancy     (redundancy),
    .segment_num_max(segment_num_max),
    .maxdetect      (maxdetect),
    .pkt_done       (pkt_done),
    .pkt_start      (pkt_start),
    .txid           (txid),
    .segment_num    (segment_num),
    .busy           (busy),
    .frame_done     (frame_done),
    .timeout_err    (timeout_err)
  );

  always #4 clk125MHz = ~clk125MHz;

  always @(posedge clk125MHz) cyc <= cyc + 1;

  always @(negedge clk125MHz) begin
    if (pkt_start === 1'b1) n_start++;
    if (frame_done === 1'b1) n_fd++;
  end

  task automatic tick();
    @(posedge clk125MHz);
    #1;
  endtask

  task automatic wait_start(output int t);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      if (pkt_start === 1'b1) begin
        t = cyc;
        return;
      end
      tick();
    end
    checks++;
    errors++;
    $display("FAIL wait_start: got no pkt_start within 400 cycles, expected one");
  endtask

  task automatic wait_frame_done(output int t);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      if (frame_done === 1'b1) begin
        t = cyc;
        return;
      end
      tick();
    end
    checks++;
    errors++;
    $display("FAIL wait_frame_done: got no frame_done within 400 cycles, expected one");
  endtask

  // Called in the pkt_start cycle; pkt_done lands dly cycles later.
  task automatic send_done(input int dly, input bit md);
    repeat (dly) tick();
    pkt_done  = 1'b1;
    maxdetect = md;
    tick();
    pkt_done  = 1'b0;
    maxdetect = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (pkt_start !== 1'b0) begin errors++; $display("FAIL reset_pkt_start: got %b expected 0", pkt_start); end
    checks++; if (txid !== 8'd1) begin errors++; $display("FAIL reset_txid: got %0d expected 1", txid); end
    checks++; if (segment_num !== 16'd0) begin errors++; $display("FAIL reset_seg: got %0d expected 0", segment_num); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int t0, t1, t2, tf, s0, f0;
    s0 = n_start; f0 = n_fd;
    redundancy = 8'd1; segment_num_max = 16'd1; enable = 1'b1;
    wait_start(t0);
    enable = 1'b0;
    checks++; if (txid !== 8'd1 || segment_num !== 16'd0) begin errors++; $display("FAIL t1_tuple0: got (%0d,%0d) expected (1,0)", txid, segment_num); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b expected 1", busy); end
    send_done(100, 1'b0);
    wait_start(t1);
    checks++; if (t1 - t0 !== 113) begin errors++; $display("FAIL t1_spacing1: got %0d expected 113", t1 - t0); end
    checks++; if (txid !== 8'd1 || segment_num !== 16'd0) begin errors++; $display("FAIL t1_tuple1: got (%0d,%0d) expected (1,0)", txid, segment_num); end
    send_done(100, 1'b0);
    wait_start(t2);
    checks++; if (t2 - t1 !== 113) begin errors++; $display("FAIL t1_spacing2: got %0d expected 113", t2 - t1); end
    send_done(100, 1'b1);
    wait_frame_done(tf);
    checks++; if (tf - t2 !== 113) begin errors++; $display("FAIL t1_frame_done_time: got %0d expected 113", tf - t2); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_idle_busy: got %b expected 0", busy); end
    repeat (20) tick();
    checks++; if (n_start - s0 !== 3) begin errors++; $display("FAIL t1_pkt_count: got %0d expected 3", n_start - s0); end
    checks++; if (n_fd - f0 !== 1) begin errors++; $display("FAIL t1_frame_count: got %0d expected 1", n_fd - f0); end
  endtask

  task automatic test_multi_group();
    int t, tp, tf, s0, f0;
    s0 = n_start; f0 = n_fd; tp = 0;
    redundancy = 8'd3; segment_num_max = 16'd2; enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_start(t);
      if (i == 0) enable = 1'b0;
      checks++; if (txid !== t2_id[i] || segment_num !== t2_seg[i]) begin errors++; $display("FAIL t2_tuple%0d: got (%0d,%0d) expected (%0d,%0d)", i, txid, segment_num, t2_id[i], t2_seg[i]); end
      if (i > 0) begin
        checks++; if (t - tp !== 33) begin errors++; $display("FAIL t2_spacing%0d: got %0d expected 33", i, t - tp); end
      end
      tp = t;
      send_done(20, i == 0);
    end
    wait_frame_done(tf);
    checks++; if (tf - tp !== 33) begin errors++; $display("FAIL t2_frame_done_time: got %0d expected 33", tf - tp); end
    repeat (10) tick();
    checks++; if (n_start - s0 !== 6) begin errors++; $display("FAIL t2_pkt_count: got %0d expected 6", n_start - s0); end
    checks++; if (n_fd - f0 !== 1) begin errors++; $display("FAIL t2_frame_count: got %0d expected 1", n_fd - f0); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL t2_timeout_err: got %b expected 0", timeout_err); end
  endtask

  task automatic test_zero_config();
    int t0, t1, t2, t3, tf;
    redundancy = 8'd0; segment_num_max = 16'd0; enable = 1'b1;
    wait_start(t0);
    enable = 1'b0;
    redundancy = 8'd4; segment_num_max = 16'd5;
    checks++; if (txid !== 8'd1 || segment_num !== 16'd0) begin errors++; $display("FAIL t3_tuple0: got (%0d,%0d) expected (1,0)", txid, segment_num); end
    send_done(10, 1'b0);
    wait_start(t1);
    checks++; if (t1 - t0 !== 23) begin errors++; $display("FAIL t3_spacing: got %0d expected 23", t1 - t0); end
    checks++; if (txid !== 8'd1 || segment_num !== 16'd0) begin errors++; $display("FAIL t3_tuple1: got (%0d,%0d) expected (1,0)", txid, segment_num); end
    enable = 1'b1;
    send_done(10, 1'b1);
    wait_frame_done(tf);
    checks++; if (tf - t1 !== 23) begin errors++; $display("FAIL t3_frame_done_time: got %0d expected 23", tf - t1); end
    wait_start(t2);
    enable = 1'b0;
    checks++; if (t2 - tf !== 2) begin errors++; $display("FAIL t3_restart_gap: got %0d expected 2", t2 - tf); end
    checks++; if (txid !== 8'd1 || segment_num !== 16'd0) begin errors++; $display("FAIL t3_new_tuple0: got (%0d,%0d) expected (1,0)", txid, segment_num); end
    send_done(10, 1'b0);
    wait_start(t3);
    checks++; if (txid !== 8'd1 || segment_num !== 16'd1) begin errors++; $display("FAIL t3_new_tuple1: got (%0d,%0d) expected (1,1)", txid, segment_num); end
  endtask

  task automatic test_reset_mid_packet();
    int t, s0, f0;
    enable = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s0 = n_start; f0 = n_fd;
    redundancy = 8'd2; segment_num_max = 16'd2; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_start(t);
      if (i == 0) enable = 1'b0;
      checks++; if (txid !== t4_id[i] || segment_num !== t4_seg[i]) begin errors++; $display("FAIL t4_tuple%0d: got (%0d,%0d) expected (%0d,%0d)", i, txid, segment_num, t4_id[i], t4_seg[i]); end
      if (i < 3) send_done(5, 1'b0);
    end
    repeat (5) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t4_busy_wait: got %b expected 1", busy); end
    rst = 1'b1;
    tick();
    checks++; if (pkt_start !== 1'b0) begin errors++; $display("FAIL t4_rst_pkt_start: got %b expected 0", pkt_start); end
    checks++; if (txid !== 8'd1 || segment_num !== 16'd0) begin errors++; $display("FAIL t4_rst_tuple: got (%0d,%0d) expected (1,0)", txid, segment_num); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_rst_busy: got %b expected 0", busy); end
    rst = 1'b0;
    repeat (30) tick();
    checks++; if (n_fd - f0 !== 0) begin errors++; $display("FAIL t4_no_frame_done: got %0d expected 0", n_fd - f0); end
    checks++; if (n_start - s0 !== 4) begin errors++; $display("FAIL t4_pkt_count: got %0d expected 4", n_start - s0); end
  endtask

  task automatic test_spurious_done();
    int t0, t1, tf, s0, f0;
    s0 = n_start; f0 = n_fd;
    redundancy = 8'd1; segment_num_max = 16'd2; enable = 1'b0;
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0 || n_start - s0 !== 0) begin errors++; $display("FAIL t5_idle_spurious: got busy=%b starts=%0d expected busy=0 starts=0", busy, n_start - s0); end
    enable = 1'b1;
    wait_start(t0);
    enable = 1'b0;
    send_done(10, 1'b0);
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    wait_start(t1);
    checks++; if (t1 - t0 !== 23) begin errors++; $display("FAIL t5_gap_spurious_spacing: got %0d expected 23", t1 - t0); end
    checks++; if (txid !== 8'd1 || segment_num !== 16'd1) begin errors++; $display("FAIL t5_tuple1: got (%0d,%0d) expected (1,1)", txid, segment_num); end
    send_done(10, 1'b1);
    wait_frame_done(tf);
    checks++; if (tf - t1 !== 23) begin errors++; $display("FAIL t5_frame_done_time: got %0d expected 23", tf - t1); end
    repeat (10) tick();
    checks++; if (n_start - s0 !== 2) begin errors++; $display("FAIL t5_pkt_count: got %0d expected 2", n_start - s0); end
    checks++; if (n_fd - f0 !== 1) begin errors++; $display("FAIL t5_frame_count: got %0d expected 1", n_fd - f0); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_multi_group();
    test_zero_config();
    test_reset_mid_packet();
    test_spurious_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
